// File: rtl/countdown_sequencer.sv
// Frame-synchronous sequencer driving the "3","2","1","GO" prompt enables; registered outputs, one cycle latency.
// Enables only change on the edge after a frame tick. Start is ignored while busy, and abort returns to idle.
module countdown_sequencer #(
  parameter int unsigned FRAMES_PER_STEP = 60,
  parameter int unsigned FRAME_LINE      = 480,
  parameter int unsigned CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [9:0] vCount,
  output logic       en_3,
  output logic       en_2,
  output logic       en_1,
  output logic       en_go,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    S3   = 3'd2,
    S2   = 3'd3,
    S1   = 3'd4,
    SGO  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [9:0]       LINE     = 10'(FRAME_LINE);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fl_q, fl_d;
  logic             en_3_q, en_3_d;
  logic             en_2_q, en_2_d;
  logic             en_1_q, en_1_d;
  logic             en_go_q, en_go_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic   at_line;
  logic   tick;
  logic   show;
  logic   step_last;
  state_t show_next;

  always_comb begin
    at_line   = (vCount == LINE);
    fl_d      = at_line;
    // First cycle of the blanking line only, whatever the pixel-enable rate.
    tick      = at_line && !fl_q;
    step_last = (cnt_q == LAST_CNT);
    show      = 1'b0;
    show_next = IDLE;

    state_d   = state_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = ARM;
        end
      end
      ARM: begin
        if (abort) begin
          state_d = IDLE;
        end else if (tick) begin
          state_d = S3;
          cnt_d   = '0;
        end
      end
      S3: begin
        show      = 1'b1;
        show_next = S2;
      end
      S2: begin
        show      = 1'b1;
        show_next = S1;
      end
      S1: begin
        show      = 1'b1;
        show_next = SGO;
      end
      SGO: begin
        show      = 1'b1;
        show_next = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (show) begin
      if (abort) begin
        state_d = IDLE;
      end else if (tick) begin
        if (step_last) begin
          cnt_d   = '0;
          state_d = show_next;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    if (state_d == IDLE) begin
      cnt_d = '0;
    end

    // Outputs are decoded from the next state so they register on the same edge as the transition.
    en_3_d  = (state_d == S3);
    en_2_d  = (state_d == S2);
    en_1_d  = (state_d == S1);
    en_go_d = (state_d == SGO);
    busy_d  = (state_d != IDLE);
    done_d  = (state_q == SGO) && (state_d == IDLE) && !abort;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fl_q    <= 1'b1;
      en_3_q  <= 1'b0;
      en_2_q  <= 1'b0;
      en_1_q  <= 1'b0;
      en_go_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fl_q    <= fl_d;
      en_3_q  <= en_3_d;
      en_2_q  <= en_2_d;
      en_1_q  <= en_1_d;
      en_go_q <= en_go_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign en_3  = en_3_q;
  assign en_2  = en_2_q;
  assign en_1  = en_1_q;
  assign en_go = en_go_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Scoreboard bench: stimulus queues expected output changes {en_3,en_2,en_1,en_go,busy,done} with their cycle,
// monitors pop and compare whenever either instance's outputs change. dut0 uses 2 frames/step, dut1 uses 1.
module tb_countdown_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] vCount = 10'd0;
  logic       start0 = 1'b0, abort0 = 1'b0;
  logic       start1 = 1'b0, abort1 = 1'b0;
  logic       en_3_0, en_2_0, en_1_0, en_go_0, busy_0, done_0;
  logic       en_3_1, en_2_1, en_1_1, en_go_1, busy_1, done_1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int         cyc;
    logic [5:0] v;
    string      nm;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  logic [5:0] prev0, prev1, cur0, cur1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  countdown_sequencer #(.FRAMES_PER_STEP(2), .FRAME_LINE(480), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0), .vCount(vCount),
    .en_3(en_3_0), .en_2(en_2_0), .en_1(en_1_0), .en_go(en_go_0), .busy(busy_0), .done(done_0)
  );

  countdown_sequencer #(.FRAMES_PER_STEP(1), .FRAME_LINE(480), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .vCount(vCount),
    .en_3(en_3_1), .en_2(en_2_1), .en_1(en_1_1), .en_go(en_go_1), .busy(busy_1), .done(done_1)
  );

  task automatic push(input int d, input int c, input logic [5:0] v, input string nm);
    ev_t e;
    e.cyc = c;
    e.v   = v;
    e.nm  = nm;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic check_ev(input int d, input logic [5:0] v);
    ev_t e;
    bit  empty;
    checks++;
    empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
    if (empty) begin
      failures++;
      $display("FAIL dut%0d unexpected_change: got outputs=%b at cycle %0d, expected no change", d, v, cyc);
    end else begin
      if (d == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      if (e.cyc != cyc || e.v !== v) begin
        failures++;
        $display("FAIL dut%0d %s: got outputs=%b at cycle %0d, expected %b at cycle %0d",
                 d, e.nm, v, cyc, e.v, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      cur0 = {en_3_0, en_2_0, en_1_0, en_go_0, busy_0, done_0};
      cur1 = {en_3_1, en_2_1, en_1_1, en_go_1, busy_1, done_1};
      if (cur0 !== prev0) begin
        check_ev(0, cur0);
        prev0 = cur0;
      end
      if (cur1 !== prev1) begin
        check_ev(1, cur1);
        prev1 = cur1;
      end
      checks++;
      if (!$onehot0({en_3_0, en_2_0, en_1_0, en_go_0}) || !$onehot0({en_3_1, en_2_1, en_1_1, en_go_1})) begin
        failures++;
        $display("FAIL onehot: got en0=%b en1=%b at cycle %0d, expected at most one high",
                 {en_3_0, en_2_0, en_1_0, en_go_0}, {en_3_1, en_2_1, en_1_1, en_go_1}, cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One 8-cycle frame: tick lands on the next edge, blanking line held 3 cycles, then 5 active cycles.
  task automatic frame();
    vCount = 10'd480;
    repeat (3) step();
    vCount = 10'd0;
    repeat (5) step();
  endtask

  initial begin
    int t;
    repeat (3) step();
    rst = 1'b0;
    step();

    checks++;
    if ({en_3_0, en_2_0, en_1_0, en_go_0, busy_0, done_0} !== 6'b0) begin
      failures++;
      $display("FAIL reset_dut0: got %b, expected 000000", {en_3_0, en_2_0, en_1_0, en_go_0, busy_0, done_0});
    end
    checks++;
    if ({en_3_1, en_2_1, en_1_1, en_go_1, busy_1, done_1} !== 6'b0) begin
      failures++;
      $display("FAIL reset_dut1: got %b, expected 000000", {en_3_1, en_2_1, en_1_1, en_go_1, busy_1, done_1});
    end
    prev0 = 6'b0;
    prev1 = 6'b0;
    mon_en = 1'b1;

    // Full run with 2 frames per prompt, plus a start pulse during S1 that must be ignored.
    start0 = 1'b1; push(0, cyc + 1, 6'b000010, "t1_busy"); step(); start0 = 1'b0;
    repeat (2) step();
    push(0, cyc + 1, 6'b100010, "t1_en3"); frame();
    frame();
    push(0, cyc + 1, 6'b010010, "t1_en2"); frame();
    frame();
    push(0, cyc + 1, 6'b001010, "t1_en1"); frame();
    start0 = 1'b1; step(); start0 = 1'b0;
    frame();
    push(0, cyc + 1, 6'b000110, "t1_ego"); frame();
    frame();
    t = cyc + 1;
    push(0, t, 6'b000001, "t1_done");
    push(0, t + 1, 6'b000000, "t1_idle");
    frame();

    // start and abort together in idle: nothing happens.
    start0 = 1'b1; abort0 = 1'b1; start1 = 1'b1; abort1 = 1'b1;
    step();
    start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
    repeat (5) step();

    // Blanking line held 800 cycles gives one tick; reset during the line gives none.
    start1 = 1'b1; push(1, cyc + 1, 6'b000010, "t2_busy"); step(); start1 = 1'b0;
    repeat (2) step();
    vCount = 10'd480;
    push(1, cyc + 1, 6'b100010, "t2_hold_en3");
    repeat (800) step();
    rst = 1'b1; push(1, cyc + 1, 6'b000000, "t2_rst"); step(); rst = 1'b0;
    start1 = 1'b1; push(1, cyc + 1, 6'b000010, "t2_rearm"); step(); start1 = 1'b0;
    repeat (20) step();
    vCount = 10'd0;
    repeat (4) step();
    push(1, cyc + 1, 6'b100010, "t2_return_en3"); frame();
    abort1 = 1'b1; push(1, cyc + 1, 6'b000000, "t2_abort"); step(); abort1 = 1'b0;
    repeat (3) step();

    // Abort in S2 after one tick, then restart and abort again in S3.
    start0 = 1'b1; push(0, cyc + 1, 6'b000010, "t3_busy"); step(); start0 = 1'b0;
    push(0, cyc + 1, 6'b100010, "t3_en3"); frame();
    frame();
    push(0, cyc + 1, 6'b010010, "t3_en2"); frame();
    frame();
    abort0 = 1'b1; push(0, cyc + 1, 6'b000000, "t3_abort_s2"); step(); abort0 = 1'b0;
    repeat (3) step();
    start0 = 1'b1; push(0, cyc + 1, 6'b000010, "t3_rebusy"); step(); start0 = 1'b0;
    push(0, cyc + 1, 6'b100010, "t3_reen3"); frame();
    abort0 = 1'b1; push(0, cyc + 1, 6'b000000, "t3_abort_s3"); step(); abort0 = 1'b0;
    repeat (3) step();

    // start held high with 1 frame per prompt: back-to-back runs, busy low for one cycle between.
    start1 = 1'b1; push(1, cyc + 1, 6'b000010, "t4_busy"); step();
    push(1, cyc + 1, 6'b100010, "t4_en3"); frame();
    push(1, cyc + 1, 6'b010010, "t4_en2"); frame();
    push(1, cyc + 1, 6'b001010, "t4_en1"); frame();
    push(1, cyc + 1, 6'b000110, "t4_ego"); frame();
    t = cyc + 1;
    push(1, t, 6'b000001, "t4_done1");
    push(1, t + 1, 6'b000010, "t4_retrigger");
    frame();
    push(1, cyc + 1, 6'b100010, "t4_en3b"); frame();
    start1 = 1'b0;
    push(1, cyc + 1, 6'b010010, "t4_en2b"); frame();
    push(1, cyc + 1, 6'b001010, "t4_en1b"); frame();
    push(1, cyc + 1, 6'b000110, "t4_egob"); frame();
    t = cyc + 1;
    push(1, t, 6'b000001, "t4_done2");
    push(1, t + 1, 6'b000000, "t4_idle");
    frame();
    repeat (10) step();

    checks++;
    if (q0.size() != 0) begin
      failures++;
      $display("FAIL dut0_pending: got %0d unseen events (next %s), expected 0", q0.size(), q0[0].nm);
    end
    checks++;
    if (q1.size() != 0) begin
      failures++;
      $display("FAIL dut1_pending: got %0d unseen events (next %s), expected 0", q1.size(), q1[0].nm);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
